ppu_vram_responder: RTL and testbench
=====================================

# ppu_vram_responder

Memory-side responder for the PPU's internal address bus. It services the single-cycle read/write requests issued by the PPU rendering/CPU-access logic on the 14-bit PPU address space. It decodes each request to one of three regions:
- CHR pattern space, via an external synchronous memory port.
- 2 KB internal nametable RAM with cartridge-selected mirroring.
- 32-entry palette RAM with hardware mirrors.

Reads return data with a fixed 2-cycle latency, fully pipelined. It sits between the PPU rendering FSM and the cartridge CHR interface.

## Interface
Parameters:
- CHR_WRITABLE, 0, 1 = CHR-RAM cartridge (writes forwarded), 0 = CHR-ROM (CHR writes dropped)

Ports:
- clk  in  1  PPU clock (25 MHz)
- rst  in  1  reset, asynchronous, active-low
- ppu_addr  in  14  request address
- ppu_wr_data  in  8  write data (driven by requester's ppu_data_out)
- ppu_read_request  in  1  single-cycle read strobe
- ppu_wr_request  in  1  single-cycle write strobe
- ppu_rd_data  out  8  read data (to requester's ppu_data_in)
- ppu_rd_valid  out  1  one-cycle qualifier for ppu_rd_data
- mirror_vertical  in  1  1 = vertical, 0 = horizontal nametable mirroring
- chr_addr  out  13  CHR address
- chr_rd_en  out  1  CHR read strobe
- chr_wr_en  out  1  CHR write strobe (stays 0 when CHR_WRITABLE=0)
- chr_wr_data  out  8  CHR write data
- chr_rd_data  in  8  CHR data, valid one cycle after chr_rd_en
- req_collision  out  1  sticky error: read and write requested in the same cycle

## Operation
- Region decode on ppu_addr:
  - addr[13]=0 → CHR.
  - addr[13:8]=6'h3F → palette.
  - Otherwise → nametable (0x3000–0x3EFF aliases 0x2000–0x2EFF).
- Nametable index (11 bit):
  - Vertical mirroring: {addr[10], addr[9:0]}.
  - Horizontal mirroring: {addr[11], addr[9:0]}.
  - mirror_vertical is sampled per request, with no internal state.
- Palette index is addr[4:0]. When addr[4]=1 and addr[1:0]=0, bit 4 is cleared, so 0x3F10/14/18/1C alias 0x3F00/04/08/0C.
  - Storage is 6 bits; writes keep wr_data[5:0].
  - Reads return {2'b00, entry}.
  - All 0x3F20–0x3FFF addresses alias via addr[4:0].
- CHR writes with CHR_WRITABLE=0 are discarded silently, with no error.
- Read and write asserted in the same cycle:
  - The write is performed.
  - The read is dropped, so no ppu_rd_valid.
  - req_collision is set to 1 and holds until reset.
- No ready/backpressure: a request may be accepted every cycle.
- Pipeline stages:
  - S1 (edge k): latch region, index, read/write, data; drive chr_addr/chr_rd_en/chr_wr_en registered.
  - S2 (edge k+1): NT RAM read/write and palette access; CHR data returns.
  - S3 (edge k+2): output mux registers ppu_rd_data and asserts ppu_rd_valid.
- Writes never produce ppu_rd_valid.

## Timing
- Read sampled at edge k:
  - ppu_rd_valid is high for exactly the cycle after edge k+2.
  - ppu_rd_data is valid in that same cycle and holds its last value afterwards.
- CHR read sampled at edge k:
  - chr_rd_en is high for one cycle after edge k.
  - chr_rd_data is captured at edge k+2.
- Back-to-back reads return in issue order, one per cycle, with no bubbles.
- A write at edge k followed by a read of the same location at edge k+1 returns the new data. For the CHR region this is the external memory's responsibility.
- Reset values (asynchronous assert): ppu_rd_data=0, ppu_rd_valid=0, chr_addr=0, chr_rd_en=0, chr_wr_en=0, chr_wr_data=0, req_collision=0, all palette entries=0.
- Nametable RAM contents are not reset.
- Reset during an in-flight read: the pipeline valid bits clear and no ppu_rd_valid is produced after release.
- The first request is accepted at the first clk edge after rst deasserts.

## Structure
- Shared package ppu_pkg holds:
  - Region encoding (REG_CHR, REG_NT, REG_PAL).
  - Address constants 14'h2000 and 6'h3F.
  - NT_DEPTH=2048 and PAL_DEPTH=32.
- One sub-module: ppu_nt_ram (2048×8 single-port synchronous RAM, 1-cycle read, write-first), for BRAM inference.
- Palette is a register array inside the top module.

## Test plan
1. Reset: hold rst=0 with random requests → all outputs 0. Release, then read 0x3F00 → ppu_rd_valid after 2 edges with data 0x00.
2. Vertical mirroring:
   - Write 0x2005=A5 and 0x2405=5A.
   - Read 0x2805 → A5; read 0x2C05 → 5A; read 0x3005 → A5.
   - Each read has 2-cycle latency.
3. Horizontal mirroring: write 0x2400=11 and 0x2800=22, then read 0x2000 → 11, 0x2C00 → 22.
4. Palette:
   - Write 0x3F10=FF → read 0x3F00 → 3F; read 0x3F30 → 3F.
   - Write 0x3F11=12 → read 0x3F01 unchanged (00).
5. CHR pipeline:
   - Reads 0x0000, 0x0001, 0x1FFF on consecutive cycles against a model (data = addr[7:0]^8'hC3).
   - chr_addr sequence 0000/0001/1FFF.
   - ppu_rd_valid high 3 consecutive cycles with C3, C2, 3C.
   - A CHR write with CHR_WRITABLE=0 → chr_wr_en stays 0.
6. Collision and mid-flight reset:
   - Read+write to 0x2000=77 in the same cycle → no ppu_rd_valid, req_collision=1. Subsequent read 0x2000 → 77.
   - Issue a read, then assert rst one cycle later → no ppu_rd_valid, and req_collision clears to 0.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg
// Shared definitions for the PPU address-bus responder: region encoding,
// address-space constants, memory depths and small decode helpers that
// turn a 14-bit PPU address into a region, a nametable RAM index or a
// palette entry index.

package ppu_pkg;

  // Which backing store a request targets
  typedef enum logic [1:0] {
    REG_CHR = 2'd0,
    REG_NT  = 2'd1,
    REG_PAL = 2'd2
  } region_t;

  localparam logic [13:0] NT_BASE   = 14'h2000;
  localparam logic [5:0]  PAL_PAGE  = 6'h3F;

  localparam int NT_DEPTH  = 2048;
  localparam int PAL_DEPTH = 32;
  localparam int NT_AW     = $clog2(NT_DEPTH);
  localparam int PAL_AW    = $clog2(PAL_DEPTH);

  // Everything below 0x2000 is cartridge pattern space; the last 256-byte
  // page is palette; the remainder (including the 0x3000 alias) is nametable.
  function automatic region_t decode_region(input logic [13:0] addr);
    if (addr < NT_BASE) begin
      return REG_CHR;
    end else if (addr[13:8] == PAL_PAGE) begin
      return REG_PAL;
    end else begin
      return REG_NT;
    end
  endfunction

  // Mirroring picks which address bit selects the physical 1 KB page.
  function automatic logic [NT_AW-1:0] nt_index(input logic [11:0] addr_lo,
                                                input logic        vertical);
    return vertical ? {addr_lo[10], addr_lo[9:0]} : {addr_lo[11], addr_lo[9:0]};
  endfunction

  // Sprite backdrop entries 0x10/14/18/1C share storage with 0x00/04/08/0C.
  function automatic logic [PAL_AW-1:0] pal_index(input logic [4:0] addr_lo);
    logic [PAL_AW-1:0] idx;
    idx = addr_lo;
    if (addr_lo[4] && (addr_lo[1:0] == 2'b00)) begin
      idx[4] = 1'b0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ppu_nt_ram.sv
// ppu_nt_ram
// 2048 x 8 single-port synchronous RAM backing the two physical nametable
// pages. One-cycle read latency, write-first: a write also presents the new
// data on rdata. No reset on contents or output so it maps onto block RAM.
// Ports:
//   clk   - clock
//   en    - access enable (read or write)
//   we    - write enable, qualified by en
//   addr  - 11-bit word index
//   wdata - write data
//   rdata - registered read data

module ppu_nt_ram
  import ppu_pkg::*;
(
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [NT_AW-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [NT_DEPTH];

  // Write-first port: a write returns the freshly written byte
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ppu_vram_responder.sv
// ppu_vram_responder
// Memory-side responder on the PPU's internal 14-bit address bus. Each
// single-cycle request is decoded to CHR (external port), nametable RAM
// (with cartridge mirroring) or palette RAM. Reads return after a fixed
// two-edge latency through a three-stage pipeline; a request can be taken
// every cycle.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   ppu_addr, ppu_wr_data         - request address / write data
//   ppu_read_request, ppu_wr_request - single-cycle strobes
//   ppu_rd_data, ppu_rd_valid     - read response and its one-cycle qualifier
//   mirror_vertical               - nametable mirroring select, per request
//   chr_addr, chr_rd_en, chr_wr_en, chr_wr_data, chr_rd_data - CHR memory port
//   req_collision                 - sticky flag: read and write in one cycle

module ppu_vram_responder
  import ppu_pkg::*;
#(
  parameter bit CHR_WRITABLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] ppu_addr,
  input  logic [7:0]  ppu_wr_data,
  input  logic        ppu_read_request,
  input  logic        ppu_wr_request,
  output logic [7:0]  ppu_rd_data,
  output logic        ppu_rd_valid,
  input  logic        mirror_vertical,
  output logic [12:0] chr_addr,
  output logic        chr_rd_en,
  output logic        chr_wr_en,
  output logic [7:0]  chr_wr_data,
  input  logic [7:0]  chr_rd_data,
  output logic        req_collision
);

  region_t req_region;
  logic    rd_accept;
  logic    chr_rd_go;
  logic    chr_wr_go;

  logic              s1_rd;
  logic              s1_wr;
  region_t           s1_region;
  logic [NT_AW-1:0]  s1_nt_idx;
  logic [PAL_AW-1:0] s1_pal_idx;
  logic [7:0]        s1_wdata;

  logic              s2_rd;
  region_t           s2_region;
  logic [5:0]        s2_pal_data;

  logic [5:0]        pal_mem [PAL_DEPTH];

  logic              nt_en;
  logic              nt_we;
  logic [7:0]        nt_rdata;
  logic [7:0]        rd_mux;

  // Request decode. A simultaneous write wins, so the read is dropped here.
  always_comb begin
    req_region = decode_region(ppu_addr);
    rd_accept  = ppu_read_request & ~ppu_wr_request;
    chr_rd_go  = rd_accept & (req_region == REG_CHR);
    chr_wr_go  = CHR_WRITABLE & ppu_wr_request & (req_region == REG_CHR);
  end

  // Stage 1: capture the decoded request for the internal memories
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_rd      <= 1'b0;
      s1_wr      <= 1'b0;
      s1_region  <= REG_CHR;
      s1_nt_idx  <= '0;
      s1_pal_idx <= '0;
      s1_wdata   <= '0;
    end else begin
      s1_rd      <= rd_accept;
      s1_wr      <= ppu_wr_request;
      s1_region  <= req_region;
      s1_nt_idx  <= nt_index(ppu_addr[11:0], mirror_vertical);
      s1_pal_idx <= pal_index(ppu_addr[4:0]);
      s1_wdata   <= ppu_wr_data;
    end
  end

  // Stage 1: registered CHR port; address and write data only move when a
  // strobe is actually issued, so the port is quiet for dropped ROM writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chr_addr    <= '0;
      chr_rd_en   <= 1'b0;
      chr_wr_en   <= 1'b0;
      chr_wr_data <= '0;
    end else begin
      chr_rd_en <= chr_rd_go;
      chr_wr_en <= chr_wr_go;
      if (chr_rd_go || chr_wr_go) begin
        chr_addr <= ppu_addr[12:0];
      end
      if (chr_wr_go) begin
        chr_wr_data <= ppu_wr_data;
      end
    end
  end

  // Sticky collision flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_collision <= 1'b0;
    end else if (ppu_read_request && ppu_wr_request) begin
      req_collision <= 1'b1;
    end
  end

  // Stage 2: nametable RAM access
  always_comb begin
    nt_en = (s1_rd | s1_wr) & (s1_region == REG_NT);
    nt_we = s1_wr & (s1_region == REG_NT);
  end

  ppu_nt_ram u_nt_ram (
    .clk   (clk),
    .en    (nt_en),
    .we    (nt_we),
    .addr  (s1_nt_idx),
    .wdata (s1_wdata),
    .rdata (nt_rdata)
  );

  // Stage 2: palette storage keeps only the low six bits of each write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        pal_mem[i] <= '0;
      end
    end else if (s1_wr && (s1_region == REG_PAL)) begin
      pal_mem[s1_pal_idx] <= s1_wdata[5:0];
    end
  end

  // Stage 2: carry read qualifier and region alongside the memory reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_rd       <= 1'b0;
      s2_region   <= REG_CHR;
      s2_pal_data <= '0;
    end else begin
      s2_rd       <= s1_rd;
      s2_region   <= s1_region;
      s2_pal_data <= pal_mem[s1_pal_idx];
    end
  end

  // Stage 3 source select; CHR data arrives straight from the external port
  always_comb begin
    rd_mux = '0;
    case (s2_region)
      REG_CHR: rd_mux = chr_rd_data;
      REG_NT:  rd_mux = nt_rdata;
      REG_PAL: rd_mux = {2'b00, s2_pal_data};
      default: rd_mux = '0;
    endcase
  end

  // Stage 3: response register; data holds between responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ppu_rd_data  <= '0;
      ppu_rd_valid <= 1'b0;
    end else begin
      ppu_rd_valid <= s2_rd;
      if (s2_rd) begin
        ppu_rd_data <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_ppu_vram_responder.sv
// tb_ppu_vram_responder
// Self-checking bench for ppu_vram_responder (CHR-ROM build). A behavioural
// model tracks nametable/palette contents, the expected response stream
// (queued with due cycles) and the expected CHR port; a compare process
// checks every output on every falling edge. Directed sequences pin the
// model with literal values, then randomized traffic exercises all regions.

`timescale 1ns/1ps

module tb_ppu_vram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] ppu_addr;
  logic [7:0]  ppu_wr_data;
  logic        ppu_read_request;
  logic        ppu_wr_request;
  logic [7:0]  ppu_rd_data;
  logic        ppu_rd_valid;
  logic        mirror_vertical;
  logic [12:0] chr_addr;
  logic        chr_rd_en;
  logic        chr_wr_en;
  logic [7:0]  chr_wr_data;
  logic [7:0]  chr_rd_data = 8'h00;
  logic        req_collision;

  ppu_vram_responder #(.CHR_WRITABLE(1'b0)) dut (
    .clk              (clk),
    .rst              (rst),
    .ppu_addr         (ppu_addr),
    .ppu_wr_data      (ppu_wr_data),
    .ppu_read_request (ppu_read_request),
    .ppu_wr_request   (ppu_wr_request),
    .ppu_rd_data      (ppu_rd_data),
    .ppu_rd_valid     (ppu_rd_valid),
    .mirror_vertical  (mirror_vertical),
    .chr_addr         (chr_addr),
    .chr_rd_en        (chr_rd_en),
    .chr_wr_en        (chr_wr_en),
    .chr_wr_data      (chr_wr_data),
    .chr_rd_data      (chr_rd_data),
    .req_collision    (req_collision)
  );

  // 25 MHz PPU clock
  always #20 clk = ~clk;

  // External CHR-ROM: data = addr[7:0] ^ C3, one cycle after the read strobe
  always @(posedge clk) begin
    if (chr_rd_en) begin
      chr_rd_data <= chr_addr[7:0] ^ 8'hC3;
    end
  end

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic [7:0]  nt_model [2048];
  logic [5:0]  pal_model [32];
  exp_t        exp_q [$];
  int          cyc = 0;
  logic [7:0]  last_data = 8'h00;
  logic        exp_coll = 1'b0;
  logic        exp_chr_rd_en = 1'b0;
  logic [12:0] exp_chr_addr = '0;
  bit          mon_on = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Which of the two physical 1 KB pages the logical nametable maps to
  function automatic int ntIdx(input int a, input bit vert);
    int n;
    int page;
    n    = (a % 4096) / 1024;
    page = vert ? (n % 2) : (n / 2);
    return page * 1024 + (a % 1024);
  endfunction

  function automatic int palIdx(input int a);
    int i;
    i = a % 32;
    if (i >= 16 && (i % 4) == 0) i = i - 16;
    return i;
  endfunction

  function automatic logic [7:0] modelRead(input int a, input bit vert);
    if (a < 'h2000) return 8'((a % 256) ^ 'hC3);
    else if (a >= 'h3F00) return {2'b00, pal_model[palIdx(a)]};
    else return nt_model[ntIdx(a, vert)];
  endfunction

  // Reference model: applies each accepted request at the edge it is sampled
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      exp_coll      = 1'b0;
      exp_chr_rd_en = 1'b0;
      exp_chr_addr  = '0;
      for (int i = 0; i < 32; i++) pal_model[i] = 6'h00;
    end else begin
      cyc = cyc + 1;
      exp_chr_rd_en = 1'b0;
      if (ppu_wr_request) begin
        if (int'(ppu_addr) >= 'h3F00) pal_model[palIdx(int'(ppu_addr))] = ppu_wr_data[5:0];
        else if (int'(ppu_addr) >= 'h2000) nt_model[ntIdx(int'(ppu_addr), mirror_vertical)] = ppu_wr_data;
      end
      if (ppu_read_request && ppu_wr_request) begin
        exp_coll = 1'b1;
      end else if (ppu_read_request) begin
        exp_q.push_back('{due: cyc + 2, data: modelRead(int'(ppu_addr), mirror_vertical)});
        if (int'(ppu_addr) < 'h2000) begin
          exp_chr_rd_en = 1'b1;
          exp_chr_addr  = ppu_addr[12:0];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst) begin
        last_data = 8'h00;
        checkOutput("rst rd_data", 16'(ppu_rd_data), 16'h0);
        checkOutput("rst rd_valid", 16'(ppu_rd_valid), 16'h0);
        checkOutput("rst chr_addr", 16'(chr_addr), 16'h0);
        checkOutput("rst chr_rd_en", 16'(chr_rd_en), 16'h0);
        checkOutput("rst chr_wr_en", 16'(chr_wr_en), 16'h0);
        checkOutput("rst chr_wr_data", 16'(chr_wr_data), 16'h0);
        checkOutput("rst collision", 16'(req_collision), 16'h0);
      end else begin
        logic exp_v;
        exp_v = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          exp_v     = 1'b1;
          last_data = exp_q[0].data;
          void'(exp_q.pop_front());
        end
        checkOutput("mon rd_valid", 16'(ppu_rd_valid), 16'(exp_v));
        checkOutput("mon rd_data", 16'(ppu_rd_data), 16'(last_data));
        checkOutput("mon chr_rd_en", 16'(chr_rd_en), 16'(exp_chr_rd_en));
        checkOutput("mon chr_addr", 16'(chr_addr), 16'(exp_chr_addr));
        checkOutput("mon chr_wr_en", 16'(chr_wr_en), 16'h0);
        checkOutput("mon chr_wr_data", 16'(chr_wr_data), 16'h0);
        checkOutput("mon collision", 16'(req_collision), 16'(exp_coll));
      end
    end
  end

  // Drive one request cycle on the falling edge
  task automatic applyStimulus(input bit rd, input bit wr, input logic [13:0] a, input logic [7:0] d);
    @(negedge clk);
    ppu_read_request = rd;
    ppu_wr_request   = wr;
    ppu_addr         = a;
    ppu_wr_data      = d;
  endtask

  task automatic writeReq(input logic [13:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, a, d);
  endtask

  // Single read followed by idle; response expected in the third cycle
  task automatic readCheck(input logic [13:0] a, input logic [7:0] exp, input string name);
    applyStimulus(1'b1, 1'b0, a, 8'h00);
    applyStimulus(1'b0, 1'b0, 14'h0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    checkOutput({name, " valid"}, 16'(ppu_rd_valid), 16'h1);
    checkOutput(name, 16'(ppu_rd_data), 16'(exp));
  endtask

  // Hard stop if the sequence ever stalls
  initial begin
    #10_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ppu_read_request = 1'b0;
    ppu_wr_request   = 1'b0;
    ppu_addr         = '0;
    ppu_wr_data      = '0;
    mirror_vertical  = 1'b1;
    rst              = 1'b1;
    #1 rst = 1'b0;
    #1 mon_on = 1'b1;

    // Reset held with random traffic, then idle and release
    $display("[TB] reset phase");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 14'($urandom), 8'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 14'h0, 8'h00);
    checkOutput("reset rd_valid", 16'(ppu_rd_valid), 16'h0);
    checkOutput("reset collision", 16'(req_collision), 16'h0);
    #5 rst = 1'b1;
    readCheck(14'h3F00, 8'h00, "pal 3F00 after reset");

    // Give every nametable byte a known value
    $display("[TB] nametable fill");
    mirror_vertical = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      writeReq(14'(14'h2000 + i), 8'($urandom));
    end

    // Vertical mirroring
    $display("[TB] vertical mirroring");
    writeReq(14'h2005, 8'hA5);
    writeReq(14'h2405, 8'h5A);
    readCheck(14'h2805, 8'hA5, "vert 2805");
    readCheck(14'h2C05, 8'h5A, "vert 2C05");
    readCheck(14'h3005, 8'hA5, "vert 3005");

    // Horizontal mirroring
    $display("[TB] horizontal mirroring");
    mirror_vertical = 1'b0;
    writeReq(14'h2400, 8'h11);
    writeReq(14'h2800, 8'h22);
    readCheck(14'h2000, 8'h11, "horiz 2000");
    readCheck(14'h2C00, 8'h22, "horiz 2C00");

    // Palette aliasing and 6-bit storage
    $display("[TB] palette");
    writeReq(14'h3F10, 8'hFF);
    readCheck(14'h3F00, 8'h3F, "pal 3F00 alias");
    readCheck(14'h3F30, 8'h3F, "pal 3F30 alias");
    writeReq(14'h3F11, 8'h12);
    readCheck(14'h3F01, 8'h00, "pal 3F01 untouched");

    // CHR pipeline, back-to-back reads
    $display("[TB] CHR pipeline");
    applyStimulus(1'b1, 1'b0, 14'h0000, 8'h00);
    applyStimulus(1'b1, 1'b0, 14'h0001, 8'h00);
    checkOutput("chr_addr #1", 16'(chr_addr), 16'h0000);
    checkOutput("chr_rd_en #1", 16'(chr_rd_en), 16'h1);
    applyStimulus(1'b1, 1'b0, 14'h1FFF, 8'h00);
    checkOutput("chr_addr #2", 16'(chr_addr), 16'h0001);
    applyStimulus(1'b0, 1'b0, 14'h0, 8'h00);
    checkOutput("chr_addr #3", 16'(chr_addr), 16'h1FFF);
    checkOutput("chr rd #1 valid", 16'(ppu_rd_valid), 16'h1);
    checkOutput("chr rd #1 data", 16'(ppu_rd_data), 16'hC3);
    @(negedge clk);
    checkOutput("chr rd #2 valid", 16'(ppu_rd_valid), 16'h1);
    checkOutput("chr rd #2 data", 16'(ppu_rd_data), 16'hC2);
    @(negedge clk);
    checkOutput("chr rd #3 valid", 16'(ppu_rd_valid), 16'h1);
    checkOutput("chr rd #3 data", 16'(ppu_rd_data), 16'h3C);
    @(negedge clk);
    checkOutput("chr rd idle valid", 16'(ppu_rd_valid), 16'h0);
    checkOutput("chr rd data hold", 16'(ppu_rd_data), 16'h3C);
    writeReq(14'h0123, 8'h5A);
    applyStimulus(1'b0, 1'b0, 14'h0, 8'h00);
    checkOutput("chr rom wr_en", 16'(chr_wr_en), 16'h0);

    // Collision: write performed, read dropped, flag sticks
    $display("[TB] collision");
    applyStimulus(1'b1, 1'b1, 14'h2000, 8'h77);
    applyStimulus(1'b0, 1'b0, 14'h0, 8'h00);
    checkOutput("collision set", 16'(req_collision), 16'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("collision no valid", 16'(ppu_rd_valid), 16'h0);
    readCheck(14'h2000, 8'h77, "after collision 2000");
    checkOutput("collision sticky", 16'(req_collision), 16'h1);

    // Reset with a read in flight
    $display("[TB] mid-flight reset");
    applyStimulus(1'b1, 1'b0, 14'h2005, 8'h00);
    applyStimulus(1'b0, 1'b0, 14'h0, 8'h00);
    #5 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst valid a", 16'(ppu_rd_valid), 16'h0);
    checkOutput("midrst collision", 16'(req_collision), 16'h0);
    @(negedge clk);
    #5 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midrst valid after", 16'(ppu_rd_valid), 16'h0);
    end

    // Randomized traffic over all regions, mirroring and collisions
    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      int r;
      int sel;
      logic [13:0] a;
      r   = int'($urandom_range(0, 99));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       a = 14'($urandom_range(0, 'h1FFF));
        1:       a = 14'('h2000 + $urandom_range(0, 'h1EFF));
        default: a = 14'('h3F00 + $urandom_range(0, 'hFF));
      endcase
      mirror_vertical = 1'($urandom);
      applyStimulus(r < 45, (r >= 40) && (r < 75), a, 8'($urandom));
    end
    applyStimulus(1'b0, 1'b0, 14'h0, 8'h00);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
